// File: rtl/caliptra_ss_apb_fabric_pkg.sv
// Shared types and constants for the Caliptra SS APB fabric.
package caliptra_ss_apb_fabric_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDsSetup,
    StDsAccess,
    StResp
  } fabric_state_e;

  localparam int unsigned MaxTgt   = 8;
  localparam int unsigned ErrRdata = 0;

  // Width of a target index; a single-target fabric still carries one bit.
  function automatic int unsigned tgt_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/caliptra_ss_apb_fabric_if.sv
// Upstream completer and downstream requester signals of the APB fabric.
interface caliptra_ss_apb_fabric_if #(
  parameter int unsigned NUM_TGT = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);
  logic                      s_psel;
  logic                      s_penable;
  logic [ADDR_W-1:0]         s_paddr;
  logic [2:0]                s_pprot;
  logic                      s_pwrite;
  logic [DATA_W-1:0]         s_pwdata;
  logic [DATA_W/8-1:0]       s_pstrb;
  logic [DATA_W-1:0]         s_prdata;
  logic                      s_pready;
  logic                      s_pslverr;

  logic [NUM_TGT-1:0]        m_psel;
  logic                      m_penable;
  logic [ADDR_W-1:0]         m_paddr;
  logic [2:0]                m_pprot;
  logic                      m_pwrite;
  logic [DATA_W-1:0]         m_pwdata;
  logic [DATA_W/8-1:0]       m_pstrb;
  logic [NUM_TGT*DATA_W-1:0] m_prdata;
  logic [NUM_TGT-1:0]        m_pready;
  logic [NUM_TGT-1:0]        m_pslverr;

  // Fabric side.
  modport slave (
    input  s_psel, s_penable, s_paddr, s_pprot, s_pwrite, s_pwdata, s_pstrb,
    output s_prdata, s_pready, s_pslverr,
    output m_psel, m_penable, m_paddr, m_pprot, m_pwrite, m_pwdata, m_pstrb,
    input  m_prdata, m_pready, m_pslverr
  );

  // Environment side: upstream requester plus downstream targets.
  modport master (
    output s_psel, s_penable, s_paddr, s_pprot, s_pwrite, s_pwdata, s_pstrb,
    input  s_prdata, s_pready, s_pslverr,
    input  m_psel, m_penable, m_paddr, m_pprot, m_pwrite, m_pwdata, m_pstrb,
    output m_prdata, m_pready, m_pslverr
  );
endinterface

// File: rtl/caliptra_ss_apb_addr_dec.sv
// Combinational base/mask priority decoder; the lowest matching index wins.
module caliptra_ss_apb_addr_dec
  import caliptra_ss_apb_fabric_pkg::*;
#(
  parameter int unsigned               NUM_TGT  = 2,
  parameter int unsigned               ADDR_W   = 32,
  parameter logic [NUM_TGT*ADDR_W-1:0] TGT_BASE = {32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_TGT*ADDR_W-1:0] TGT_MASK = {32'hFFFF_0000, 32'hFFFF_0000}
) (
  input  logic [ADDR_W-1:0]                 paddr_i,
  output logic                              hit_o,
  output logic [tgt_idx_w(NUM_TGT)-1:0]     idx_o,
  output logic [NUM_TGT-1:0]                onehot_o
);
  localparam int unsigned IdxW = tgt_idx_w(NUM_TGT);

  always_comb begin
    hit_o    = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    // Scan downwards so a lower-index match overrides any higher one.
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if ((paddr_i & TGT_MASK[i*ADDR_W +: ADDR_W]) ==
          (TGT_BASE[i*ADDR_W +: ADDR_W] & TGT_MASK[i*ADDR_W +: ADDR_W])) begin
        hit_o = 1'b1;
        idx_o = IdxW'(i);
      end
    end
    if (hit_o) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/caliptra_ss_apb_fabric.sv
// APB fabric: one upstream completer fanned out to NUM_TGT registered requesters.
// Optional downstream wait timeout: define CALIPTRA_SS_APB_TIMEOUT_EN.
module caliptra_ss_apb_fabric
  import caliptra_ss_apb_fabric_pkg::*;
#(
  parameter int unsigned               NUM_TGT        = 2,
  parameter int unsigned               ADDR_W         = 32,
  parameter int unsigned               DATA_W         = 32,
  parameter logic [NUM_TGT*ADDR_W-1:0] TGT_BASE       = {32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_TGT*ADDR_W-1:0] TGT_MASK       = {32'hFFFF_0000, 32'hFFFF_0000},
  parameter int unsigned               TIMEOUT_CYCLES = 256
) (
  input logic                 core_clk,
  input logic                 cptra_rst_b,
  caliptra_ss_apb_fabric_if.slave bus
);
  localparam int unsigned IdxW  = tgt_idx_w(NUM_TGT);
  localparam int unsigned StrbW = DATA_W / 8;

  if (NUM_TGT < 1 || NUM_TGT > MaxTgt) begin : g_bad_num_tgt
    $error("NUM_TGT out of range");
  end

  fabric_state_e       state_q;
  logic [IdxW-1:0]     idx_q;
  logic [NUM_TGT-1:0]  psel_q;
  logic                penable_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [2:0]          pprot_q;
  logic                pwrite_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [StrbW-1:0]    pstrb_q;
  logic [DATA_W-1:0]   prdata_q;
  logic                pready_q;
  logic                pslverr_q;

  logic                dec_hit;
  logic [IdxW-1:0]     dec_idx;
  logic [NUM_TGT-1:0]  dec_onehot;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;
  logic                tmo_expire;

  caliptra_ss_apb_addr_dec #(
    .NUM_TGT  (NUM_TGT),
    .ADDR_W   (ADDR_W),
    .TGT_BASE (TGT_BASE),
    .TGT_MASK (TGT_MASK)
  ) u_addr_dec (
    .paddr_i  (bus.s_paddr),
    .hit_o    (dec_hit),
    .idx_o    (dec_idx),
    .onehot_o (dec_onehot)
  );

  assign sel_ready = bus.m_pready[idx_q];
  assign sel_err   = bus.m_pslverr[idx_q];
  assign sel_rdata = bus.m_prdata[int'(idx_q)*DATA_W +: DATA_W];

`ifdef CALIPTRA_SS_APB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] tmo_cnt_q;

  // Expires on the wait cycle that would bring the count to TIMEOUT_CYCLES.
  assign tmo_expire = (state_q == StDsAccess) && !sel_ready &&
                      (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge core_clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      tmo_cnt_q <= '0;
    end else if (state_q == StDsAccess && !sel_ready && !tmo_expire) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo_expire     = 1'b0;
`endif

  always_ff @(posedge core_clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pprot_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.s_psel && bus.s_penable) begin
            idx_q <= dec_idx;
            if (dec_hit) begin
              psel_q   <= dec_onehot;
              paddr_q  <= bus.s_paddr;
              pprot_q  <= bus.s_pprot;
              pwrite_q <= bus.s_pwrite;
              pwdata_q <= bus.s_pwdata;
              pstrb_q  <= bus.s_pstrb;
              state_q  <= StDsSetup;
            end else begin
              // Unmapped: answer locally, downstream stays quiet.
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
              prdata_q  <= DATA_W'(ErrRdata);
              state_q   <= StResp;
            end
          end
        end
        StDsSetup: begin
          penable_q <= 1'b1;
          state_q   <= StDsAccess;
        end
        StDsAccess: begin
          if (sel_ready || tmo_expire) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pprot_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pready_q  <= 1'b1;
            pslverr_q <= sel_ready ? sel_err : 1'b1;
            prdata_q  <= (sel_ready && !sel_err && !pwrite_q) ? sel_rdata
                                                              : DATA_W'(ErrRdata);
            state_q   <= StResp;
          end
        end
        StResp: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.m_psel    = psel_q;
  assign bus.m_penable = penable_q;
  assign bus.m_paddr   = paddr_q;
  assign bus.m_pprot   = pprot_q;
  assign bus.m_pwrite  = pwrite_q;
  assign bus.m_pwdata  = pwdata_q;
  assign bus.m_pstrb   = pstrb_q;
  assign bus.s_prdata  = prdata_q;
  assign bus.s_pready  = pready_q;
  assign bus.s_pslverr = pslverr_q;

endmodule

// File: tb/tb_caliptra_ss_apb_fabric.sv
// Directed self-checking bench for caliptra_ss_apb_fabric with two behavioural targets.
module tb_caliptra_ss_apb_fabric;

  logic clk;
  logic rst_b;

  caliptra_ss_apb_fabric_if #(.NUM_TGT(2), .ADDR_W(32), .DATA_W(32)) bus ();

  caliptra_ss_apb_fabric #(
    .NUM_TGT        (2),
    .ADDR_W         (32),
    .DATA_W         (32),
    .TGT_BASE       ({32'h0001_0000, 32'h0000_0000}),
    .TGT_MASK       ({32'hFFFF_0000, 32'hFFFF_0000}),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .core_clk    (clk),
    .cptra_rst_b (rst_b),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Behavioural targets: per-target wait states, read data and error.
  int          waits [2];
  int          wcnt  [2];
  logic [31:0] rd    [2];
  logic        errc  [2];
  logic        tog0;
  logic        tgl;

  initial begin
    bus.m_pready  = '0;
    bus.m_pslverr = '0;
    bus.m_prdata  = '0;
    tgl = 1'b0;
    forever begin
      @(negedge clk);
      tgl = ~tgl;
      bus.m_prdata = {rd[1], rd[0]};
      for (int i = 0; i < 2; i++) begin
        if (bus.m_psel[i] && bus.m_penable) begin
          if (wcnt[i] < waits[i]) begin
            bus.m_pready[i]  = 1'b0;
            bus.m_pslverr[i] = 1'b0;
            wcnt[i]++;
          end else begin
            bus.m_pready[i]  = 1'b1;
            bus.m_pslverr[i] = errc[i];
          end
        end else begin
          wcnt[i]          = 0;
          bus.m_pready[i]  = 1'b0;
          bus.m_pslverr[i] = 1'b0;
        end
      end
      // Noise on an unselected target 0 must not affect the fabric.
      if (tog0 && !bus.m_psel[0]) begin
        bus.m_pready[0]  = tgl;
        bus.m_pslverr[0] = tgl;
      end
    end
  end

  logic [1:0]  seen_psel;
  logic [31:0] seen_paddr;
  logic [31:0] seen_pwdata;
  logic [3:0]  seen_pstrb;
  logic        seen_pwrite;
  logic [2:0]  seen_pprot;

  // Full upstream transfer; lat counts cycles from the first ACCESS cycle to s_pready.
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic err, output int lat);
    @(negedge clk);
    bus.s_psel    = 1'b1;
    bus.s_penable = 1'b0;
    bus.s_paddr   = addr;
    bus.s_pwrite  = wr;
    bus.s_pwdata  = wdata;
    bus.s_pstrb   = strb;
    bus.s_pprot   = 3'b010;
    seen_psel   = '0;
    seen_paddr  = '0;
    seen_pwdata = '0;
    seen_pstrb  = '0;
    seen_pwrite = 1'b0;
    seen_pprot  = '0;
    @(negedge clk);
    bus.s_penable = 1'b1;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.m_psel != 2'b00 && seen_psel == 2'b00) begin
        seen_psel   = bus.m_psel;
        seen_paddr  = bus.m_paddr;
        seen_pwdata = bus.m_pwdata;
        seen_pstrb  = bus.m_pstrb;
        seen_pwrite = bus.m_pwrite;
        seen_pprot  = bus.m_pprot;
      end
      if (bus.s_pready) break;
    end
    check_eq("pready_seen", 32'(bus.s_pready), 32'd1);
    rdata = bus.s_prdata;
    err   = bus.s_pslverr;
    bus.s_psel    = 1'b0;
    bus.s_penable = 1'b0;
  endtask

  logic [31:0] rdata;
  logic        err;
  int          lat;
  bit          got_access;

  initial begin
    rst_b = 1'b0;
    bus.s_psel = 1'b0; bus.s_penable = 1'b0; bus.s_paddr = '0; bus.s_pprot = '0;
    bus.s_pwrite = 1'b0; bus.s_pwdata = '0; bus.s_pstrb = '0;
    waits[0] = 0; waits[1] = 0; wcnt[0] = 0; wcnt[1] = 0;
    rd[0] = 32'hA5A5_0001; rd[1] = 32'h5A5A_0002;
    errc[0] = 1'b0; errc[1] = 1'b0; tog0 = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_s_pready",  32'(bus.s_pready),  32'd0);
    check_eq("rst_s_pslverr", 32'(bus.s_pslverr), 32'd0);
    check_eq("rst_s_prdata",  bus.s_prdata,        32'd0);
    check_eq("rst_m_psel",    32'(bus.m_psel),     32'd0);
    check_eq("rst_m_penable", 32'(bus.m_penable),  32'd0);
    check_eq("rst_m_paddr",   bus.m_paddr,         32'd0);
    rst_b = 1'b1;
    @(negedge clk);

    // Zero-wait read of target 0.
    apb_xfer(32'h0000_0010, 1'b0, 32'h0, 4'hF, rdata, err, lat);
    check_eq("t0rd_psel",  32'(seen_psel), 32'h1);
    check_eq("t0rd_paddr", seen_paddr,     32'h0000_0010);
    check_eq("t0rd_pprot", 32'(seen_pprot), 32'h2);
    check_eq("t0rd_rdata", rdata,          32'hA5A5_0001);
    check_eq("t0rd_err",   32'(err),       32'd0);
    check_eq("t0rd_lat",   32'(lat),       32'd3);

    // Write to target 1 with two wait states.
    waits[1] = 2;
    apb_xfer(32'h0001_0004, 1'b1, 32'h1234_5678, 4'b0011, rdata, err, lat);
    check_eq("t1wr_psel",   32'(seen_psel),   32'h2);
    check_eq("t1wr_paddr",  seen_paddr,       32'h0001_0004);
    check_eq("t1wr_pwdata", seen_pwdata,      32'h1234_5678);
    check_eq("t1wr_pstrb",  32'(seen_pstrb),  32'h3);
    check_eq("t1wr_pwrite", 32'(seen_pwrite), 32'd1);
    check_eq("t1wr_lat",    32'(lat),         32'd5);
    check_eq("t1wr_err",    32'(err),         32'd0);
    check_eq("t1wr_rdata",  rdata,            32'd0);
    @(negedge clk);
    check_eq("idle_m_paddr",  bus.m_paddr,  32'd0);
    check_eq("idle_m_pwdata", bus.m_pwdata, 32'd0);
    check_eq("idle_s_pready", 32'(bus.s_pready), 32'd0);

    // Unmapped read answered locally.
    apb_xfer(32'h0002_0000, 1'b0, 32'h0, 4'hF, rdata, err, lat);
    check_eq("miss_psel",  32'(seen_psel), 32'd0);
    check_eq("miss_lat",   32'(lat),       32'd1);
    check_eq("miss_err",   32'(err),       32'd1);
    check_eq("miss_rdata", rdata,          32'd0);

    // Target 1 error on write while target 0 toggles ready/error.
    waits[1] = 0; errc[1] = 1'b1; tog0 = 1'b1;
    apb_xfer(32'h0001_0000, 1'b1, 32'hDEAD_BEEF, 4'hF, rdata, err, lat);
    check_eq("t1err_err",   32'(err), 32'd1);
    check_eq("t1err_rdata", rdata,    32'd0);
    check_eq("t1err_lat",   32'(lat), 32'd3);

    // Target 1 read with waits; target 0 noise must not end or fail it.
    errc[1] = 1'b0; waits[1] = 2;
    apb_xfer(32'h0001_0010, 1'b0, 32'h0, 4'hF, rdata, err, lat);
    check_eq("t1rd_rdata", rdata,    32'h5A5A_0002);
    check_eq("t1rd_err",   32'(err), 32'd0);
    check_eq("t1rd_lat",   32'(lat), 32'd5);
    tog0 = 1'b0;

    // Target 0 read error returns zero data.
    errc[0] = 1'b1;
    apb_xfer(32'h0000_0020, 1'b0, 32'h0, 4'hF, rdata, err, lat);
    check_eq("t0err_err",   32'(err), 32'd1);
    check_eq("t0err_rdata", rdata,    32'd0);
    errc[0] = 1'b0;

`ifdef CALIPTRA_SS_APB_TIMEOUT_EN
    // Target 1 never ready: four ACCESS cycles then local error.
    waits[1] = 1000;
    apb_xfer(32'h0001_0000, 1'b0, 32'h0, 4'hF, rdata, err, lat);
    check_eq("tmo_err",   32'(err), 32'd1);
    check_eq("tmo_rdata", rdata,    32'd0);
    check_eq("tmo_lat",   32'(lat), 32'd6);
    waits[1] = 0;
    apb_xfer(32'h0000_0010, 1'b0, 32'h0, 4'hF, rdata, err, lat);
    check_eq("tmo_next_rdata", rdata,    32'hA5A5_0001);
    check_eq("tmo_next_lat",   32'(lat), 32'd3);
`endif

    // Asynchronous reset while stalled in DS_ACCESS.
    waits[1] = 1000;
    @(negedge clk);
    bus.s_psel = 1'b1; bus.s_penable = 1'b0; bus.s_paddr = 32'h0001_0008; bus.s_pwrite = 1'b0;
    @(negedge clk);
    bus.s_penable = 1'b1;
    got_access = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.m_penable) got_access = 1'b1;
    end
    check_eq("rstmid_access", 32'(got_access), 32'd1);
    #2 rst_b = 1'b0;
    #1;
    check_eq("rstmid_m_psel",    32'(bus.m_psel),    32'd0);
    check_eq("rstmid_m_penable", 32'(bus.m_penable), 32'd0);
    check_eq("rstmid_s_pready",  32'(bus.s_pready),  32'd0);
    check_eq("rstmid_m_paddr",   bus.m_paddr,        32'd0);
    @(negedge clk);
    bus.s_psel = 1'b0; bus.s_penable = 1'b0;
    waits[1] = 0;
    @(negedge clk);
    rst_b = 1'b1;
    apb_xfer(32'h0000_0010, 1'b0, 32'h0, 4'hF, rdata, err, lat);
    check_eq("post_rst_rdata", rdata,    32'hA5A5_0001);
    check_eq("post_rst_err",   32'(err), 32'd0);
    check_eq("post_rst_lat",   32'(lat), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/caliptra_ss_apb_fabric.md
Name: caliptra_ss_apb_fabric

Overview:
Parametrised APB fabric with one upstream completer port and NUM_TGT downstream requester ports. It is the next-generation replacement for the fixed one-APB-per-wrapper wiring in the FPGA package top. Each upstream transfer is decoded by base/mask, then reissued as a registered APB transfer to exactly one target. The response comes back upstream with PREADY and PSLVERR. Unmapped addresses are answered locally with an error.

Parameters:
NUM_TGT, 2, number of downstream targets (1..8)
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TGT_BASE, {32'h0001_0000, 32'h0000_0000}, packed NUM_TGT*ADDR_W base addresses; target i is slice i
TGT_MASK, {32'hFFFF_0000, 32'hFFFF_0000}, packed NUM_TGT*ADDR_W match masks
TIMEOUT_CYCLES, 256, downstream ACCESS-phase wait limit; used only with the timeout feature

Ports:
core_clk  in  1  fabric clock
cptra_rst_b  in  1  asynchronous active-low reset
s_psel  in  1  upstream select
s_penable  in  1  upstream enable
s_paddr  in  ADDR_W  upstream address
s_pprot  in  3  upstream protection
s_pwrite  in  1  upstream write
s_pwdata  in  DATA_W  upstream write data
s_pstrb  in  DATA_W/8  upstream byte strobes
s_prdata  out  DATA_W  upstream read data
s_pready  out  1  upstream ready
s_pslverr  out  1  upstream error
m_psel  out  NUM_TGT  one-hot downstream select
m_penable  out  1  downstream enable (shared)
m_paddr  out  ADDR_W  downstream address (shared)
m_pprot  out  3  downstream protection (shared)
m_pwrite  out  1  downstream write (shared)
m_pwdata  out  DATA_W  downstream write data (shared)
m_pstrb  out  DATA_W/8  downstream strobes (shared)
m_prdata  in  NUM_TGT*DATA_W  packed read data
m_pready  in  NUM_TGT  per-target ready
m_pslverr  in  NUM_TGT  per-target error

Behaviour:
- Clock/reset: one clock, core_clk. cptra_rst_b is asynchronous, active-low.
- Reset values: all outputs are 0; state is IDLE; the timeout counter is 0.
- Reset asserted mid-transfer immediately drops m_psel, m_penable and s_pready. No response is generated for that transfer.
- Decode: target i hits when (s_paddr & mask_i) == (base_i & mask_i).
  - If targets overlap, the lowest index wins.
  - No hit is a miss.
- IDLE:
  - On s_psel & s_penable, register paddr, pprot, pwrite, pwdata, pstrb and the decode result.
  - Hit -> DS_SETUP. Miss -> RESP with error=1, rdata=0.
- DS_SETUP (1 cycle): m_psel[hit]=1, m_penable=0, then -> DS_ACCESS.
- DS_ACCESS:
  - m_psel[hit]=1, m_penable=1.
  - On m_pready[hit]=1, capture m_prdata slice and m_pslverr[hit], drop m_psel/m_penable next cycle, and go to RESP.
  - Ready/error from non-selected targets is ignored.
- RESP (1 cycle):
  - s_pready=1, s_prdata and s_pslverr driven from registers, then -> IDLE.
  - s_prdata is 0 on writes and on errors.
- s_pready is 0 in every state except RESP.
- Latency, zero-wait target: s_pready is high 3 cycles after the first upstream ACCESS cycle. Miss: 1 cycle.
- The upstream master holds psel/penable until s_pready. The fabric does not re-sample inputs outside IDLE.
- Back-to-back: a new ACCESS seen in IDLE the cycle after RESP is accepted. There are no bubbles beyond the IDLE cycle.
- Shared m_* buses hold the captured values from DS_SETUP through DS_ACCESS, and return to 0 in IDLE.

Optional Feature:
- Macro: CALIPTRA_SS_APB_TIMEOUT_EN.
- Defined:
  - Counter increments each DS_ACCESS cycle without m_pready[hit].
  - When it reaches TIMEOUT_CYCLES: deassert m_psel/m_penable, go to RESP with s_pslverr=1, s_prdata=0, and clear the counter.
  - m_pready in the same cycle as expiry wins (normal completion).
- Undefined: DS_ACCESS waits indefinitely, and the counter logic is absent.

Decomposition:
- Package caliptra_ss_apb_fabric_pkg holds:
  - the state enum (IDLE, DS_SETUP, DS_ACCESS, RESP)
  - the max-target constant (8)
  - the error read-data constant (0)
  - the target-index width function
- Sub-module caliptra_ss_apb_addr_dec: combinational priority decoder that takes paddr and emits hit, idx and one-hot.

Test Plan:
- Read 0x0000_0010, target 0 zero-wait returns 0xA5A5_0001 -> m_psel=2'b01, s_prdata=0xA5A5_0001, s_pready 3 cycles after ACCESS, s_pslverr=0.
- Write 0x0001_0004 data 0x1234_5678, strobe 4'b0011, target 1 with 2 wait states -> m_psel=2'b10, m_pwdata/m_pstrb match, s_pready 5 cycles after ACCESS.
- Read unmapped 0x0002_0000 -> m_psel stays 0, s_pready next cycle, s_pslverr=1, s_prdata=0.
- Target 1 returns m_pslverr=1 on write -> s_pslverr=1 in RESP. Target 0 pslverr toggling at the same time is ignored.
- With CALIPTRA_SS_APB_TIMEOUT_EN and TIMEOUT_CYCLES=4, target never ready -> m_psel drops after 4 ACCESS cycles, s_pslverr=1. A following read to target 0 completes normally.
- cptra_rst_b low during DS_ACCESS -> all outputs 0 asynchronously. After release a read to target 0 succeeds.
